// File: rtl/fib_regfile.sv
// 16-entry register bank behind the Fibonacci sequencer: write-back source select,
// two zero-latency read ports, sticky overflow/bus-error flags and write statistics.
module fib_regfile #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic [3:0]        buff_ctrl,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic              clr_flags,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] last_wr,
    output logic [CNT_W-1:0]  wr_count,
    output logic              ovf_flag,
    output logic              bus_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_IMM  = 2'd1,
        SRC_ALU  = 2'd2
    } src_e;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DATA_W-1:0] r_last_wr;
    logic [CNT_W-1:0]  r_wr_count;
    logic              r_ovf_flag;
    logic              r_bus_err;

    src_e              w_src;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_commit;
    logic              w_ovf_set;
    logic              w_bus_err_set;

    // Immediate bit wins over the ALU pattern; anything else drives no bus source.
    always_comb begin
        w_src = SRC_NONE;
        if (buff_ctrl[0]) begin
            w_src = SRC_IMM;
        end else if (buff_ctrl[3:1] == 3'b111) begin
            w_src = SRC_ALU;
        end
    end

    always_comb begin
        w_wr_data     = (w_src == SRC_IMM) ? imm_in : alu_result;
        w_commit      = wr_en && (w_src != SRC_NONE);
        w_ovf_set     = wr_en && (w_src == SRC_ALU) && alu_carry;
        w_bus_err_set = wr_en && (w_src == SRC_NONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[wr_addr] <= w_wr_data;
        end
    end

    // Write statistics; the counter holds at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_wr  <= '0;
            r_wr_count <= '0;
        end else if (w_commit) begin
            r_last_wr <= w_wr_data;
            if (r_wr_count != {CNT_W{1'b1}}) begin
                r_wr_count <= r_wr_count + CNT_W'(1);
            end
        end
    end

    // Sticky flags: a set event in the same cycle as clr_flags wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf_flag <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_ovf_flag <= w_ovf_set     | (r_ovf_flag & ~clr_flags);
            r_bus_err  <= w_bus_err_set | (r_bus_err  & ~clr_flags);
        end
    end

    // No bypass: reads see pre-edge contents so R1 <= R1 + R0 uses old operands.
    assign rd_data1 = r_regs[rd_addr1];
    assign rd_data2 = r_regs[rd_addr2];

    assign last_wr  = r_last_wr;
    assign wr_count = r_wr_count;
    assign ovf_flag = r_ovf_flag;
    assign bus_err  = r_bus_err;

endmodule
